// File: rtl/mul_div_wb_arbiter.sv
// Writeback arbiter for the mult unit: merges the fixed-latency multiplier (credit-throttled FIFO)
// and the serial divider (1-entry hold register) onto one valid/ready port with anti-starvation.
module mul_div_wb_arbiter #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     mult_issue_i,
  output logic                     issue_ready_o,
  input  logic                     mult_valid_i,
  input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
  input  logic [XLEN-1:0]          mult_result_i,
  input  logic                     div_valid_i,
  output logic                     div_ready_o,
  input  logic [TRANS_ID_BITS-1:0] div_trans_id_i,
  input  logic [XLEN-1:0]          div_result_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_src_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          data;
  } res_t;

  res_t          fifo_q [DEPTH];
  res_t          hold_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [SW-1:0] starve_q;
  logic          inflight_q, hold_valid_q, drop_q;

  logic          fifo_valid, sel_div, wb_fire, mult_pop, div_pop, mult_push, div_load;
  logic [CW:0]   credits;

  // Credits count registered occupancy plus the op still inside the multiplier.
  assign credits       = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign issue_ready_o = credits < (CW+1)'(DEPTH);
  assign div_ready_o   = ~hold_valid_q;

  assign fifo_valid = count_q != '0;
  assign sel_div    = hold_valid_q & (~fifo_valid | (starve_q == SW'(STARVE_LIMIT)));
  assign wb_valid_o = (fifo_valid | hold_valid_q) & ~flush_i;
  assign wb_fire    = wb_valid_o & wb_ready_i;
  assign mult_pop   = wb_fire & ~sel_div;
  assign div_pop    = wb_fire & sel_div;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign mult_push  = mult_valid_i & ~drop_q & ((count_q != CW'(DEPTH)) | mult_pop);
  assign div_load   = div_valid_i & div_ready_o;

  always_comb begin
    wb_trans_id_o = '0;
    wb_result_o   = '0;
    wb_src_o      = 1'b0;
    if (sel_div) begin
      wb_trans_id_o = hold_q.id;
      wb_result_o   = hold_q.data;
      wb_src_o      = 1'b1;
    end else if (fifo_valid) begin
      wb_trans_id_o = fifo_q[rd_ptr_q].id;
      wb_result_o   = fifo_q[rd_ptr_q].data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mult_push) fifo_q[wr_ptr_q] <= '{id: mult_trans_id_i, data: mult_result_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      starve_q     <= '0;
      drop_q       <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      starve_q     <= '0;
      drop_q       <= 1'b1;
    end else begin
      drop_q     <= 1'b0;
      inflight_q <= mult_issue_i & issue_ready_o;
      if (mult_push)
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (mult_pop)
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      case ({mult_push, mult_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (div_pop) begin
        hold_valid_q <= 1'b0;
      end else if (div_load) begin
        hold_valid_q <= 1'b1;
        hold_q       <= '{id: div_trans_id_i, data: div_result_i};
      end
      if (!hold_valid_q || div_pop)            starve_q <= '0;
      else if (starve_q != SW'(STARVE_LIMIT))  starve_q <= starve_q + 1'b1;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    !(mult_valid_i && !drop_q && (count_q == CW'(DEPTH)) && !mult_pop))
    else $error("multiplier result pushed into full FIFO");

endmodule

// File: tb/tb_mul_div_wb_arbiter.sv
// Scoreboard bench for mul_div_wb_arbiter: expected results queued per source at drive time,
// popped and compared when the writeback port fires.
module tb_mul_div_wb_arbiter;
  localparam int XLEN = 64;
  localparam int TID  = 4;

  logic            clk_i = 0, rst_ni = 0, flush_i = 0;
  logic            mult_issue_i = 0, issue_ready_o;
  logic            mult_valid_i = 0;
  logic [TID-1:0]  mult_trans_id_i = '0;
  logic [XLEN-1:0] mult_result_i = '0;
  logic            div_valid_i = 0, div_ready_o;
  logic [TID-1:0]  div_trans_id_i = '0;
  logic [XLEN-1:0] div_result_i = '0;
  logic            wb_valid_o, wb_ready_i = 1, wb_src_o;
  logic [TID-1:0]  wb_trans_id_o;
  logic [XLEN-1:0] wb_result_o;

  mul_div_wb_arbiter #(.XLEN(XLEN), .TRANS_ID_BITS(TID), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .mult_issue_i(mult_issue_i), .issue_ready_o(issue_ready_o),
    .mult_valid_i(mult_valid_i), .mult_trans_id_i(mult_trans_id_i), .mult_result_i(mult_result_i),
    .div_valid_i(div_valid_i), .div_ready_o(div_ready_o),
    .div_trans_id_i(div_trans_id_i), .div_result_i(div_result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_trans_id_o(wb_trans_id_o),
    .wb_result_o(wb_result_o), .wb_src_o(wb_src_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [TID-1:0] id; logic [XLEN-1:0] data; } exp_t;
  exp_t mq[$];
  exp_t dq[$];

  int checks = 0, errors = 0;
  int cyc = 0, div_wb_cyc = 0, load_cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Writeback monitor: each accepted result must match the head of its source's queue.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && wb_valid_o && wb_ready_i) begin
      if (wb_src_o) begin
        if (dq.size() == 0) chk("div_unexpected", 1, 0);
        else begin
          e = dq.pop_front();
          chk("div_id", wb_trans_id_o, e.id);
          chk("div_data", wb_result_o, e.data);
          div_wb_cyc = cyc;
        end
      end else begin
        if (mq.size() == 0) chk("mult_unexpected", 1, 0);
        else begin
          e = mq.pop_front();
          chk("mult_id", wb_trans_id_o, e.id);
          chk("mult_data", wb_result_o, e.data);
        end
      end
    end
  end

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_issue_ready"}, issue_ready_o, 1);
    chk({pfx, "_div_ready"}, div_ready_o, 1);
    chk({pfx, "_wb_valid"}, wb_valid_o, 0);
    chk({pfx, "_wb_id"}, wb_trans_id_o, 0);
    chk({pfx, "_wb_result"}, wb_result_o, 0);
    chk({pfx, "_wb_src"}, wb_src_o, 0);
  endtask

  initial begin
    // Reset state
    step(); step();
    chk_reset_outs("rst");
    rst_ni = 1;

    // Single issue
    step(); mult_issue_i = 1; #1 chk("t2_issue_ready", issue_ready_o, 1);
    step(); mult_issue_i = 0; mult_valid_i = 1; mult_trans_id_i = 3; mult_result_i = 64'h2A;
    mq.push_back('{id: 4'd3, data: 64'h2A});
    step(); mult_valid_i = 0;
    #1 chk("t2_wb_valid", wb_valid_o, 1); chk("t2_src", wb_src_o, 0); chk("t2_id", wb_trans_id_o, 3);
    step(); #1 chk("t2_empty", wb_valid_o, 0); chk("t2_ready_after", issue_ready_o, 1);

    // Credit back-pressure, DEPTH = 2
    wb_ready_i = 0;
    step(); mult_issue_i = 1; #1 chk("t3_rdy_c1", issue_ready_o, 1);
    step(); mult_valid_i = 1; mult_trans_id_i = 1; mult_result_i = 64'h11;
    mq.push_back('{id: 4'd1, data: 64'h11}); #1 chk("t3_rdy_c2", issue_ready_o, 1);
    step(); mult_trans_id_i = 2; mult_result_i = 64'h22;
    mq.push_back('{id: 4'd2, data: 64'h22}); #1 chk("t3_rdy_c3", issue_ready_o, 0);
    step(); mult_issue_i = 0; mult_valid_i = 0;
    #1 chk("t3_rdy_c4", issue_ready_o, 0); chk("t3_hold_valid", wb_valid_o, 1);
    chk("t3_hold_id", wb_trans_id_o, 1);
    step(); #1 chk("t3_rdy_c5", issue_ready_o, 0);
    step(); wb_ready_i = 1;
    step(); #1 chk("t3_rdy_c7", issue_ready_o, 1);
    step(); #1 chk("t3_drained", wb_valid_o, 0);

    // Collision: divider held against a continuous multiplier stream
    div_wb_cyc = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      mult_valid_i = 1; mult_trans_id_i = TID'(k + 6); mult_result_i = 64'h1000 + 64'(k);
      mq.push_back('{id: TID'(k + 6), data: 64'h1000 + 64'(k)});
      if (k == 1) begin
        div_valid_i = 1; div_trans_id_i = 5; div_result_i = 64'hD1;
        dq.push_back('{id: 4'd5, data: 64'hD1});
        load_cyc = cyc;
        #1 chk("t4_div_ready", div_ready_o, 1);
      end else div_valid_i = 0;
    end
    step(); mult_valid_i = 0; div_valid_i = 0;
    repeat (4) step();
    chk("t4_div_written", div_wb_cyc > load_cyc, 1);
    chk("t4_starve_lat", (div_wb_cyc - load_cyc) <= 5, 1);
    chk("t4_mq_empty", mq.size(), 0);
    chk("t4_dq_empty", dq.size(), 0);

    // Divider handshake with div_valid_i held high
    step(); div_valid_i = 1; div_trans_id_i = 1; div_result_i = 64'hA1;
    dq.push_back('{id: 4'd1, data: 64'hA1}); #1 chk("t5_rdy0", div_ready_o, 1);
    step(); div_trans_id_i = 2; div_result_i = 64'hB2;
    #1 chk("t5_rdy1", div_ready_o, 0); chk("t5_wbv1", wb_valid_o, 1); chk("t5_src1", wb_src_o, 1);
    step(); dq.push_back('{id: 4'd2, data: 64'hB2}); #1 chk("t5_rdy2", div_ready_o, 1);
    step(); div_valid_i = 0;
    #1 chk("t5_wbv3", wb_valid_o, 1); chk("t5_src3", wb_src_o, 1); chk("t5_rdy3", div_ready_o, 0);
    step(); #1 chk("t5_idle", wb_valid_o, 0); chk("t5_dq_empty", dq.size(), 0);

    // Flush with full FIFO, held divider result and a same-cycle issue
    wb_ready_i = 0;
    step(); mult_valid_i = 1; mult_trans_id_i = 7; mult_result_i = 64'h77;
    div_valid_i = 1; div_trans_id_i = 9; div_result_i = 64'h99;
    step(); mult_trans_id_i = 8; mult_result_i = 64'h88; div_valid_i = 0;
    step(); mult_valid_i = 0; #1 chk("t6_pre_wbv", wb_valid_o, 1); chk("t6_pre_rdy", issue_ready_o, 0);
    step(); flush_i = 1; mult_issue_i = 1; #1 chk("t6_wbv_flush", wb_valid_o, 0);
    step(); flush_i = 0; mult_issue_i = 0; wb_ready_i = 1;
    mult_valid_i = 1; mult_trans_id_i = 10; mult_result_i = 64'hAA;
    #1 chk("t6_wbv_after", wb_valid_o, 0); chk("t6_issue_rdy", issue_ready_o, 1);
    chk("t6_div_rdy", div_ready_o, 1);
    step(); mult_valid_i = 0; #1 chk("t6_dropped", wb_valid_o, 0);
    for (int i = 0; i < 3; i++) begin
      step(); #1 chk("t6_no_wb", wb_valid_o, 0);
    end

    // Async reset while a result is pending and the FIFO is full
    wb_ready_i = 0;
    step(); mult_valid_i = 1; mult_trans_id_i = 1; mult_result_i = 64'h5;
    step(); mult_trans_id_i = 2; mult_result_i = 64'h6;
    step(); mult_valid_i = 0; #1 chk("t7_pre_wbv", wb_valid_o, 1); chk("t7_pre_rdy", issue_ready_o, 0);
    #1 rst_ni = 0;
    #1 chk_reset_outs("t7");
    step(); step(); rst_ni = 1; wb_ready_i = 1;
    step(); #1 chk("t7_post_wbv", wb_valid_o, 0);
    step();

    chk("end_mq_empty", mq.size(), 0);
    chk("end_dq_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
